// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: region decode, per-region command channels,
// in-order load tracking and a formatted result FIFO drained by WB.
module dmem_lsu #(
    parameter int              DW          = 32,
    parameter int              AW          = 32,
    parameter int              RDW         = 5,
    parameter int              NR          = 3,
    parameter logic [NR*AW-1:0] REGION_BASE = '0,
    parameter logic [NR*AW-1:0] REGION_SIZE = '0,
    parameter int              OUTST       = 4
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [AW-1:0]              req_addr,
    input  logic [DW-1:0]              req_wdata,
    input  logic [RDW-1:0]             req_rd,
    output logic [NR-1:0]              mem_cmd_valid,
    input  logic [NR-1:0]              mem_cmd_ready,
    output logic                       mem_cmd_wr,
    output logic [AW-1:0]              mem_cmd_addr,
    output logic [DW/8-1:0]            mem_cmd_strb,
    output logic [DW-1:0]              mem_cmd_wdata,
    input  logic [NR-1:0]              mem_rsp_valid,
    input  logic [NR*DW-1:0]           mem_rsp_data,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [RDW-1:0]             wb_rd,
    output logic [DW-1:0]              wb_data,
    output logic                       misalign_err,
    output logic [AW-1:0]              misalign_addr,
    output logic [$clog2(OUTST):0]     outst_cnt
);
    localparam int BL = DW / 8;
    localparam int OW = $clog2(BL);
    localparam int PW = $clog2(OUTST);
    localparam int CW = PW + 1;
    localparam int RW = (NR > 1) ? $clog2(NR) : 1;

    typedef struct packed {
        logic [RW-1:0]  region;
        logic [1:0]     size;
        logic           uns;
        logic [OW-1:0]  off;
        logic [RDW-1:0] rd;
    } trk_t;

    // Address decode: lowest matching region wins, NR-1 is the fallback.
    logic [RW-1:0] sel;
    logic [AW-1:0] sel_base;
    always_comb begin
        sel = RW'(NR - 1);
        for (int i = NR - 2; i >= 0; i--) begin
            if (req_addr >= REGION_BASE[i*AW +: AW] &&
                (req_addr - REGION_BASE[i*AW +: AW]) < REGION_SIZE[i*AW +: AW])
                sel = RW'(i);
        end
        sel_base = REGION_BASE[sel*AW +: AW];
    end

    logic [OW-1:0] off;
    logic          mis;
    logic [7:0]    mask8;
    assign off = req_addr[OW-1:0];

    always_comb begin
        mis   = 1'b0;
        mask8 = 8'h01;
        case (req_size)
            2'b00: begin mis = 1'b0;                            mask8 = 8'h01; end
            2'b01: begin mis = req_addr[0];                     mask8 = 8'h03; end
            2'b10: begin mis = |req_addr[1:0];                  mask8 = 8'h0F; end
            default: begin mis = (DW == 32) || (|req_addr[2:0]); mask8 = 8'hFF; end
        endcase
    end

    // Tracking FIFO of issued loads awaiting a response
    trk_t          trk_mem [OUTST];
    logic [PW:0]   trk_wp, trk_rp;
    logic          trk_empty;
    trk_t          trk_head, trk_tail;
    logic [PW-1:0] tail_idx;

    assign trk_empty = (trk_wp == trk_rp);
    assign tail_idx  = trk_wp[PW-1:0] - PW'(1);
    assign trk_head  = trk_mem[trk_rp[PW-1:0]];
    assign trk_tail  = trk_mem[tail_idx];

    // Result FIFO feeding WB
    logic [RDW-1:0] res_rd   [OUTST];
    logic [DW-1:0]  res_data [OUTST];
    logic [PW:0]    res_wp, res_rp;
    logic [CW-1:0]  cnt;
    logic           wb_pop;

    assign wb_valid  = (res_wp != res_rp);
    assign wb_pop    = wb_valid && wb_ready;
    assign wb_rd     = wb_valid ? res_rd[res_rp[PW-1:0]]   : '0;
    assign wb_data   = wb_valid ? res_data[res_rp[PW-1:0]] : '0;
    assign outst_cnt = cnt;

    // A WB pop frees a slot in the same cycle, so a stalled load can issue alongside it.
    logic cnt_ok, order_ok, ld_ok;
    assign cnt_ok   = (cnt < CW'(OUTST)) || wb_pop;
    assign order_ok = trk_empty || (trk_tail.region == sel);
    assign ld_ok    = !mis && cnt_ok && order_ok;

    always_comb begin
        mem_cmd_valid = '0;
        req_ready     = 1'b0;
        if (!cpu_rst) begin
            if (req_valid && !mis && (req_wr || ld_ok))
                mem_cmd_valid[sel] = 1'b1;
            if (mis)
                req_ready = 1'b1;
            else if (req_wr)
                req_ready = mem_cmd_ready[sel];
            else
                req_ready = ld_ok && mem_cmd_ready[sel];
        end
    end

    assign mem_cmd_wr    = req_wr;
    assign mem_cmd_addr  = req_addr - sel_base;
    assign mem_cmd_strb  = BL'(mask8) << off;
    assign mem_cmd_wdata = req_wdata << {off, 3'b000};

    logic accept, ld_acc, mis_acc, rsp_hit;
    assign accept  = req_valid && req_ready;
    assign ld_acc  = accept && !req_wr && !mis;
    assign mis_acc = accept && mis;
    assign rsp_hit = !trk_empty && mem_rsp_valid[trk_head.region];

    // Lane select then sign/zero extend according to the tracked size
    logic [DW-1:0] rsp_sh, keep, rsp_fmt;
    logic          sbit;
    always_comb begin
        rsp_sh = mem_rsp_data[trk_head.region*DW +: DW] >> {trk_head.off, 3'b000};
        keep   = {DW{1'b1}};
        sbit   = 1'b0;
        case (trk_head.size)
            2'b00:   begin keep = {DW{1'b1}} >> (DW - 8);  sbit = rsp_sh[7];  end
            2'b01:   begin keep = {DW{1'b1}} >> (DW - 16); sbit = rsp_sh[15]; end
            2'b10:   begin keep = {DW{1'b1}} >> (DW - 32); sbit = rsp_sh[31]; end
            default: begin keep = {DW{1'b1}};              sbit = 1'b0;       end
        endcase
        rsp_fmt = (rsp_sh & keep) | ({DW{sbit & ~trk_head.uns}} & ~keep);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            trk_wp        <= '0;
            trk_rp        <= '0;
            res_wp        <= '0;
            res_rp        <= '0;
            cnt           <= '0;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            if (ld_acc)  trk_wp <= trk_wp + (PW+1)'(1);
            if (rsp_hit) begin
                trk_rp <= trk_rp + (PW+1)'(1);
                res_wp <= res_wp + (PW+1)'(1);
            end
            if (wb_pop)  res_rp <= res_rp + (PW+1)'(1);
            case ({ld_acc, wb_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            misalign_err <= mis_acc;
            if (mis_acc) misalign_addr <= req_addr;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (ld_acc)
            trk_mem[trk_wp[PW-1:0]] <= '{region: sel, size: req_size, uns: req_unsigned,
                                         off: off, rd: req_rd};
        if (rsp_hit) begin
            res_rd[res_wp[PW-1:0]]   <= trk_head.rd;
            res_data[res_wp[PW-1:0]] <= rsp_fmt;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: stimulus pushes expected commands/results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_dmem_lsu;
    localparam int DW = 32, AW = 32, RDW = 5, NR = 3, OUTST = 4;
    localparam logic [NR*AW-1:0] BASE = {32'h0, 32'h2000_0000, 32'h0};
    localparam logic [NR*AW-1:0] SIZE = {32'h0, 32'h0001_0000, 32'h0001_0000};

    logic            cpu_clk, cpu_rst;
    logic            req_valid, req_ready, req_wr, req_unsigned;
    logic [1:0]      req_size;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [RDW-1:0]  req_rd;
    logic [NR-1:0]   mem_cmd_valid, mem_cmd_ready, mem_rsp_valid;
    logic            mem_cmd_wr;
    logic [AW-1:0]   mem_cmd_addr;
    logic [3:0]      mem_cmd_strb;
    logic [DW-1:0]   mem_cmd_wdata;
    logic [NR*DW-1:0] mem_rsp_data;
    logic            wb_valid, wb_ready;
    logic [RDW-1:0]  wb_rd;
    logic [DW-1:0]   wb_data;
    logic            misalign_err;
    logic [AW-1:0]   misalign_addr;
    logic [2:0]      outst_cnt;

    dmem_lsu #(.DW(DW), .AW(AW), .RDW(RDW), .NR(NR), .REGION_BASE(BASE),
               .REGION_SIZE(SIZE), .OUTST(OUTST)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_strb(mem_cmd_strb), .mem_cmd_wdata(mem_cmd_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_err(misalign_err), .misalign_addr(misalign_addr),
        .outst_cnt(outst_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [2:0]  oh;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wd;
    } cmd_t;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    cmd_t cmdq[$];
    wb_t  wbq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge cpu_clk) begin : mon
        cmd_t ec;
        wb_t  ew;
        if (!cpu_rst) begin
            if ((mem_cmd_valid & mem_cmd_ready) != '0) begin
                if (cmdq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL cmd_unexpected: got valid %b expected none", mem_cmd_valid);
                end else begin
                    ec = cmdq.pop_front();
                    check("cmd_valid", 64'(mem_cmd_valid), 64'(ec.oh));
                    check("cmd_wr",    64'(mem_cmd_wr),    64'(ec.wr));
                    check("cmd_addr",  64'(mem_cmd_addr),  64'(ec.addr));
                    check("cmd_strb",  64'(mem_cmd_strb),  64'(ec.strb));
                    check("cmd_wdata", 64'(mem_cmd_wdata), 64'(ec.wd));
                end
            end
            if (wb_valid && wb_ready) begin
                if (wbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL wb_unexpected: got rd %0d data %h expected none", wb_rd, wb_data);
                end else begin
                    ew = wbq.pop_front();
                    check("wb_rd",   64'(wb_rd),   64'(ew.rd));
                    check("wb_data", 64'(wb_data), 64'(ew.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic exp_cmd(input logic [2:0] oh, input logic wr, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] wd);
        cmd_t c;
        c.oh = oh; c.wr = wr; c.addr = a; c.strb = s; c.wd = wd;
        cmdq.push_back(c);
    endtask

    task automatic exp_wb(input logic [4:0] rd, input logic [31:0] d);
        wb_t w;
        w.rd = rd; w.data = d;
        wbq.push_back(w);
    endtask

    task automatic set_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_rd = rd;
    endtask

    // Called and returns at posedge+1; holds the request until accepted (bounded).
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        int n;
        n = 0;
        set_req(wr, sz, uns, a, wd, rd);
        @(negedge cpu_clk);
        while (!req_ready && n < 20) begin
            n++;
            @(negedge cpu_clk);
        end
        check("issue_accept", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic rsp(input int r, input logic [31:0] d);
        mem_rsp_valid = '0;
        mem_rsp_valid[r] = 1'b1;
        mem_rsp_data[r*32 +: 32] = d;
        tick();
        mem_rsp_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        cpu_rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_cmd_ready = 3'b111; mem_rsp_valid = '0; mem_rsp_data = '0; wb_ready = 1'b1;

        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);
        check("rst_cnt",     64'(outst_cnt),     64'(0));
        check("rst_wbv",     64'(wb_valid),      64'(0));
        check("rst_merr",    64'(misalign_err),  64'(0));
        check("rst_maddr",   64'(misalign_addr), 64'(0));
        check("rst_cmdv",    64'(mem_cmd_valid), 64'(0));
        check("rst_wbdata",  64'(wb_data),       64'(0));
        tick();
        cpu_rst = 1'b0;
        tick();

        // LW to region 1, response two cycles after acceptance
        exp_cmd(3'b010, 1'b0, 32'h10, 4'hF, 32'h0);
        exp_wb(5'd1, 32'h8765_4321);
        issue(1'b0, 2'b10, 1'b0, 32'h2000_0010, 32'h0, 5'd1);
        check("lw_cnt1", 64'(outst_cnt), 64'(1));
        tick();
        rsp(1, 32'h8765_4321);
        check("lw_latency", 64'(wb_valid),  64'(1));
        check("lw_cnt_hold", 64'(outst_cnt), 64'(1));
        tick();
        check("lw_cnt0",  64'(outst_cnt), 64'(0));
        check("lw_wbv0",  64'(wb_valid),  64'(0));

        // Byte/half loads with sign and zero extension, back to back
        exp_cmd(3'b001, 1'b0, 32'h2003, 4'b1000, 32'h0);
        exp_wb(5'd2, 32'hFFFF_FF80);
        issue(1'b0, 2'b00, 1'b0, 32'h2003, 32'h0, 5'd2);
        exp_cmd(3'b001, 1'b0, 32'h2003, 4'b1000, 32'h0);
        exp_wb(5'd3, 32'h0000_0080);
        issue(1'b0, 2'b00, 1'b1, 32'h2003, 32'h0, 5'd3);
        exp_cmd(3'b001, 1'b0, 32'h2002, 4'b1100, 32'h0);
        exp_wb(5'd4, 32'hFFFF_8001);
        issue(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 5'd4);
        check("ext_cnt3", 64'(outst_cnt), 64'(3));
        rsp(0, 32'h80FF_FFFF);
        rsp(0, 32'h80FF_FFFF);
        rsp(0, 32'h8001_0000);
        tick();
        tick();
        check("ext_cnt0", 64'(outst_cnt), 64'(0));

        // Store held off by region ready
        mem_cmd_ready = 3'b110;
        exp_cmd(3'b001, 1'b1, 32'h6, 4'b1100, 32'h1234_0000);
        set_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234, 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk);
            check("st_stall_rdy", 64'(req_ready),     64'(0));
            check("st_stall_vld", 64'(mem_cmd_valid), 64'(3'b001));
            tick();
        end
        mem_cmd_ready = 3'b111;
        @(negedge cpu_clk);
        check("st_accept", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        check("st_cnt0", 64'(outst_cnt), 64'(0));

        // Misaligned word load
        issue(1'b0, 2'b10, 1'b0, 32'h1001, 32'h0, 5'd7);
        check("mis_pulse", 64'(misalign_err),  64'(1));
        check("mis_addr",  64'(misalign_addr), 64'(32'h1001));
        check("mis_cnt",   64'(outst_cnt),     64'(0));
        tick();
        check("mis_pulse_end", 64'(misalign_err),  64'(0));
        check("mis_addr_hold", 64'(misalign_addr), 64'(32'h1001));

        // Fill OUTST with WB blocked; fifth load waits for the first pop
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_cmd(3'b001, 1'b0, 32'h100 + 32'(4*i), 4'hF, 32'h0);
            exp_wb(5'(10 + i), 32'hA000_0000 + 32'(i));
            issue(1'b0, 2'b10, 1'b0, 32'h100 + 32'(4*i), 32'h0, 5'(10 + i));
        end
        check("full_cnt", 64'(outst_cnt), 64'(4));
        exp_cmd(3'b001, 1'b0, 32'h110, 4'hF, 32'h0);
        exp_wb(5'd14, 32'hA000_0004);
        set_req(1'b0, 2'b10, 1'b0, 32'h110, 32'h0, 5'd14);
        for (int i = 0; i < 4; i++) rsp(0, 32'hA000_0000 + 32'(i));
        @(negedge cpu_clk);
        check("full_stall", 64'(req_ready), 64'(0));
        check("full_wbv",   64'(wb_valid),  64'(1));
        check("full_cnt2",  64'(outst_cnt), 64'(4));
        tick();
        wb_ready = 1'b1;
        @(negedge cpu_clk);
        check("full_issue_on_pop", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        check("full_cnt_same", 64'(outst_cnt), 64'(4));
        tick();
        rsp(0, 32'hA000_0004);
        n = 0;
        while (outst_cnt != 0 && n < 20) begin
            n++;
            tick();
        end
        check("full_drain", 64'(outst_cnt), 64'(0));

        // Cross-region ordering stall, plus a stray response on a non-head region
        exp_cmd(3'b001, 1'b0, 32'h200, 4'hF, 32'h0);
        exp_wb(5'd20, 32'h5555_AAAA);
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 5'd20);
        exp_cmd(3'b100, 1'b0, 32'h4000_0000, 4'hF, 32'h0);
        set_req(1'b0, 2'b10, 1'b0, 32'h4000_0000, 32'h0, 5'd21);
        @(negedge cpu_clk);
        check("xr_stall_rdy", 64'(req_ready),     64'(0));
        check("xr_stall_vld", 64'(mem_cmd_valid), 64'(0));
        tick();
        mem_rsp_valid = 3'b010;
        mem_rsp_data[63:32] = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = '0;
        @(negedge cpu_clk);
        check("stray_rsp_wbv", 64'(wb_valid),  64'(0));
        check("stray_rsp_cnt", 64'(outst_cnt), 64'(1));
        check("xr_stall_rdy2", 64'(req_ready), 64'(0));
        tick();
        mem_rsp_valid = 3'b001;
        mem_rsp_data[31:0] = 32'h5555_AAAA;
        @(negedge cpu_clk);
        check("xr_stall_rdy3", 64'(req_ready), 64'(0));
        tick();
        mem_rsp_valid = '0;
        @(negedge cpu_clk);
        check("xr_issue_rdy", 64'(req_ready),     64'(1));
        check("xr_issue_vld", 64'(mem_cmd_valid), 64'(3'b100));
        tick();
        req_valid = 1'b0;
        check("xr_cnt", 64'(outst_cnt), 64'(1));

        // Reset with the region-2 load still in flight
        cpu_rst = 1'b1;
        tick();
        cpu_rst = 1'b0;
        check("rst_mid_cnt", 64'(outst_cnt), 64'(0));
        check("rst_mid_wbv", 64'(wb_valid),  64'(0));
        exp_cmd(3'b001, 1'b0, 32'h300, 4'hF, 32'h0);
        exp_wb(5'd22, 32'h1357_9BDF);
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd22);
        rsp(0, 32'h1357_9BDF);
        tick();
        check("post_rst_cnt", 64'(outst_cnt), 64'(0));

        tick();
        tick();
        check("cmdq_empty", 64'(cmdq.size()), 64'(0));
        check("wbq_empty",  64'(wbq.size()),  64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised load/store unit; next generation of the MEM-stage data memory controller.
- Sits between the EX/MEM pipeline register and N memory regions (TCMs, AHB bridge).
- Decodes the address into one of NR regions, drives per-region command channels, and tracks up to OUTST in-order outstanding loads.
- Formats load data (byte/half/word/dword, signed/unsigned) into a result FIFO drained by WB with a valid/ready handshake. Flags misaligned accesses instead of issuing them.

Parameters:
- DW, 32, data width (32 or 64); byte lanes BL=DW/8.
- AW, 32, address width.
- RDW, 5, destination register index width.
- NR, 3, number of memory regions. Region NR-1 is the default (bus) region.
- REGION_BASE, {AW'h0,...}, packed NR*AW base addresses.
- REGION_SIZE, {AW'h0,...}, packed NR*AW region sizes in bytes.
- OUTST, 4, max loads in flight plus unconsumed results (power of 2, >=2).

Ports:
- cpu_clk  in  1  clock.
- cpu_rst  in  1  synchronous active-high reset.
- req_valid  in  1  MEM-stage access request.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_wr  in  1  0 load, 1 store.
- req_size  in  2  00 B, 01 H, 10 W, 11 D (legal only when DW=64).
- req_unsigned  in  1  zero-extend the load.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, LSB-aligned.
- req_rd  in  RDW  load destination.
- mem_cmd_valid  out  NR  one-hot command valid.
- mem_cmd_ready  in  NR  per-region ready.
- mem_cmd_wr  out  1  command write.
- mem_cmd_addr  out  AW  address minus selected REGION_BASE.
- mem_cmd_strb  out  BL  byte strobes.
- mem_cmd_wdata  out  DW  lane-shifted store data.
- mem_rsp_valid  in  NR  per-region read response valid. Not backpressurable.
- mem_rsp_data  in  NR*DW  per-region read data.
- wb_valid  out  1  result FIFO head valid.
- wb_ready  in  1  WB consumes the head.
- wb_rd  out  RDW  head destination.
- wb_data  out  DW  formatted load data.
- misalign_err  out  1  one-cycle pulse on an accepted misaligned request.
- misalign_addr  out  AW  captured faulting address.
- outst_cnt  out  $clog2(OUTST)+1  in-flight loads plus buffered results.

Behaviour:
- Reset: all outputs 0. FIFOs are emptied and outst_cnt=0. Reset mid-transaction discards all tracked loads; regions share cpu_rst, so no stale responses arrive afterwards.
- Decode: the request targets the lowest-index region i<NR-1 with BASE_i <= addr < BASE_i+SIZE_i; otherwise it targets NR-1. The region match is combinational from req_addr.
- Misaligned: addr mod 2^size != 0, or size=11 with DW=32.
  - req_ready=1; no mem_cmd_valid.
  - misalign_err=1 in the cycle after acceptance; misalign_addr is registered at the same time and held until the next error.
- Strobe: ((1<<2^size)-1) << addr[log2(BL)-1:0]. Write data is shifted left by 8*offset.
- Store: mem_cmd_valid[i]=req_valid && aligned. req_ready=mem_cmd_ready[i]. Stores are posted and not tracked.
- Load issue condition, all of:
  - aligned;
  - outst_cnt<OUTST;
  - tracking FIFO empty, or its newest entry targets the same region (in-order guarantee; no cross-region reordering);
  - mem_cmd_ready[i].
- req_ready equals the load issue condition. mem_cmd_valid is asserted only when all conditions except mem_cmd_ready hold.
- Tracking FIFO (depth OUTST) stores: region, size, unsigned, byte offset, rd. Pushed on load acceptance.
- Response: mem_rsp_valid[head.region] pops the tracking FIFO. Data is lane-selected and sign/zero-extended, then pushed to the result FIFO one cycle later (registered).
  - Load-to-use latency: rsp in cycle N gives wb_valid in N+1.
  - rsp_valid on a non-head region, or with the tracking FIFO empty, is ignored.
- Result FIFO (depth OUTST) drives wb_*. It pops on wb_valid&&wb_ready. It cannot overflow because outst_cnt counts every entry in both FIFOs.
- outst_cnt: +1 on load accept, -1 on wb pop. Both in the same cycle leaves it unchanged. It never exceeds OUTST.
- Simultaneous response and wb pop on a full result FIFO is legal.
- Pointers wrap modulo OUTST. The full/empty distinction uses an extra pointer bit.

Test Plan:
- NR=3, BASE={0x0,0x2000_0000,-}, SIZE={0x1_0000,0x1_0000,-}: LW 0x2000_0010, region 1 returns 0x8765_4321 two cycles later -> mem_cmd_valid=3'b010, addr=0x10, strb=4'hF; wb_data=0x8765_4321 one cycle after the response; outst_cnt 1 -> 0 on pop.
- LB 0x2003 with rsp 0x80FF_FFFF -> wb_data=0xFFFF_FF80. LBU -> 0x0000_0080. LH 0x2002 with rsp 0x8001_0000 -> 0xFFFF_8001.
- SH 0x0000_0006, wdata 0x1234 -> strb=4'b1100, wdata=0x1234_0000, region 0. Hold mem_cmd_ready=0 for 3 cycles -> req_ready=0 for those cycles, then accepted.
- LW 0x1001 -> no command; misalign_err pulses one cycle; misalign_addr=0x1001; outst_cnt stays 0.
- OUTST=4, wb_ready=0: 5 back-to-back loads to region 0 -> 4 accepted, 5th stalls with req_ready=0. Raise wb_ready -> results pop in issue order; 5th issues in the same cycle as the first pop.
- Load to region 0 outstanding, next load to region 2 -> stalled until region 0 responds, then issued. Reset asserted mid-flight -> outst_cnt=0 and wb_valid=0 the next cycle.
